fir_cmplx_decim: RTL and testbench
==================================

# fir_cmplx_decim

Decimating real-coefficient FIR filter applied to both I and Q sample streams. It sits directly downstream of the IQ read/quantize stage and consumes its sign-extended, Q10-quantized I/Q pairs through the available/read-enable handshake. For every DECIM accepted pairs it emits one filtered I/Q pair to the next demodulation stage. It uses one multiply-accumulate pair per cycle, with run-time-writable coefficients.

## Interface
- DATA_WIDTH, 32, sample and coefficient width (signed, Q(QUANTIZE_WIDTH))
- TAPS, 20, filter length
- DECIM, 8, decimation factor (≥1)
- QUANTIZE_WIDTH, 10, fractional bits removed after each product
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_avail  input  1  upstream pair valid (upstream outputAvailible)
- in_rd_en  output  1  pair consumed this cycle (drives upstream out_rd_en)
- in_i, in_q  input  DATA_WIDTH each  upstream I/Q samples
- coef_wr_en  input  1  coefficient write strobe
- coef_addr  input  $clog2(TAPS)  tap index
- coef_data  input  DATA_WIDTH  coefficient value
- out_avail  output  1  filtered pair valid
- out_rd_en  input  1  downstream consumes pair
- out_i, out_q  output  DATA_WIDTH each  filtered samples

## Operation
- History: two TAPS-deep shift registers (I, Q). x[0] is the newest sample.
- Coefficients: h[0..TAPS-1] in registers, reset to 0.
- States:
  - IDLE: in_rd_en = in_avail. On accept, the pair shifts into x[0] and dcnt increments.
    - If dcnt was DECIM-1: dcnt←0, acc_i/acc_q←0, k←0, go to MAC.
  - MAC: each cycle acc += (h[k]·x[k]) >>> QUANTIZE_WIDTH for I and Q.
    - Products are signed 64-bit; the shift is arithmetic. acc is signed 64-bit and wraps.
    - k increments. After k=TAPS-1, go to OUT. in_rd_en=0.
  - OUT: out_avail=1, in_rd_en=0. On out_rd_en=1, go to IDLE.
- out_i/out_q load from the final acc (see Configuration) on the MAC→OUT transition and hold until the next load.
- Coefficient writes:
  - Apply at the clock edge in IDLE and OUT.
  - Dropped in MAC, so a computation always uses one coefficient set.
  - Addresses ≥ TAPS are dropped.
- Unreachable state encoding: go to IDLE.

## Timing
- Reset (reset=0, asynchronous) state:
  - out_avail=0, out_i=out_q=0, in_rd_en=0.
  - History, coefficients, dcnt, acc and k all 0.
  - State = IDLE.
- Reset mid-MAC/OUT: computation is abandoned with no output. The first post-reset output needs DECIM fresh pairs.
- Latency: last pair of a group accepted at edge t → MAC on cycles t+1..t+TAPS → out_avail=1 from cycle t+TAPS+1.
- Throughput: at most one pair per cycle in IDLE. No pairs are accepted during MAC/OUT (backpressure via in_rd_en=0).
- out_avail deasserts the cycle after out_rd_en=1 is sampled. out_rd_en is ignored when out_avail=0.

## Configuration
- FIR_CMPLX_SAT_EN
  - Defined: each output clamps acc to [0x80000000, 0x7FFFFFFF] signed.
  - Undefined: output = acc[DATA_WIDTH-1:0] (wrap).

## Test plan
- Reset: hold reset=0 with in_avail=1 → in_rd_en=0, out_avail=0, out_i=out_q=0.
  - Release → in_rd_en=1 next cycle.
- Impulse: write h[k]=k·1024, feed I=1024, Q=-1024, then zeros.
  - Out 1 = (7168, -7168); out 2 = (15360, -15360); out 3 = (0, 0).
- Latency/backpressure: 8th pair accepted at edge t → out_avail at cycle t+21.
  - Hold out_rd_en=0 for 50 cycles → out_avail=1, values stable, in_rd_en=0 throughout.
- Coefficient write in MAC: write h[7]=0 during MAC of out 1 of the impulse test → out 1 still 7168.
  - A write in IDLE before the next group takes effect.
- Saturation: all h=0x40000000, all x=0x40000000.
  - With FIR_CMPLX_SAT_EN: out=0x7FFFFFFF.
  - Without it: out=0x00000000 (20·2^50 mod 2^32).
- Reset mid-MAC: reset pulse during MAC → no out_avail pulse, coefficients read back as 0 (all outputs 0 after 8 new nonzero pairs).

Source files
------------

// File: rtl/fir_cmplx_decim.sv
// Decimating real-coefficient FIR over an I/Q pair stream, one MAC per lane per cycle.
// Optional FIR_CMPLX_SAT_EN: clamp outputs to the signed DATA_WIDTH range instead of wrapping.
module fir_cmplx_decim_lane #(
  parameter int DW   = 32,
  parameter int TAPS = 20,
  parameter int QW   = 10,
  parameter int KW   = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          shift,
  input  logic          clr,
  input  logic          mac,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] h,
  input  logic [KW-1:0] k,
  output logic [DW-1:0] y
);
  logic [TAPS-1:0][DW-1:0] x;
  logic signed [63:0]      hx, xx, acc, acc_nxt;
  logic [DW-1:0]           y_nxt;

  assign hx      = 64'($signed(h));
  assign xx      = 64'($signed(x[k]));
  assign acc_nxt = acc + ((hx * xx) >>> QW);

`ifdef FIR_CMPLX_SAT_EN
  localparam logic signed [63:0] MAXV = $signed({{(65-DW){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [63:0] MINV = ~MAXV;
  always_comb begin
    y_nxt = acc_nxt[DW-1:0];
    if (acc_nxt > MAXV)      y_nxt = MAXV[DW-1:0];
    else if (acc_nxt < MINV) y_nxt = MINV[DW-1:0];
  end
`else
  assign y_nxt = acc_nxt[DW-1:0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x   <= '0;
      acc <= '0;
      y   <= '0;
    end else begin
      if (shift) x <= {x[TAPS-2:0], din};
      if (clr)      acc <= '0;
      else if (mac) acc <= acc_nxt;
      if (load) y <= y_nxt;
    end
  end
endmodule

module fir_cmplx_decim #(
  parameter int DATA_WIDTH     = 32,
  parameter int TAPS           = 20,
  parameter int DECIM          = 8,
  parameter int QUANTIZE_WIDTH = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_avail,
  output logic                    in_rd_en,
  input  logic [DATA_WIDTH-1:0]   in_i,
  input  logic [DATA_WIDTH-1:0]   in_q,
  input  logic                    coef_wr_en,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [DATA_WIDTH-1:0]   coef_data,
  output logic                    out_avail,
  input  logic                    out_rd_en,
  output logic [DATA_WIDTH-1:0]   out_i,
  output logic [DATA_WIDTH-1:0]   out_q
);
  localparam int KW        = $clog2(TAPS);
  localparam int DCW       = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int NUM_LANES = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]                             state;
  logic [KW-1:0]                          k;
  logic [DCW-1:0]                         dcnt;
  logic [TAPS-1:0][DATA_WIDTH-1:0]        coef;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]   din, y;
  logic                                   group_done, mac_last, coef_ok;

  // Gate with reset so nothing is consumed while the block is held in reset.
  assign in_rd_en   = reset && (state == S_IDLE) && in_avail;
  assign out_avail  = (state == S_OUT);
  assign group_done = in_rd_en && (dcnt == DCW'(DECIM - 1));
  assign mac_last   = (state == S_MAC) && (k == KW'(TAPS - 1));
  assign coef_ok    = coef_wr_en && (state != S_MAC) && ({1'b0, coef_addr} < (KW+1)'(TAPS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      k     <= '0;
      dcnt  <= '0;
      coef  <= '0;
    end else begin
      if (coef_ok) coef[coef_addr] <= coef_data;
      case (state)
        S_IDLE: if (in_rd_en) begin
          if (group_done) begin
            dcnt  <= '0;
            k     <= '0;
            state <= S_MAC;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_MAC: begin
          k <= mac_last ? '0 : k + 1'b1;
          if (mac_last) state <= S_OUT;
        end
        S_OUT:   if (out_rd_en) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign din   = {in_q, in_i};
  assign out_i = y[0];
  assign out_q = y[1];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fir_cmplx_decim_lane #(
      .DW(DATA_WIDTH), .TAPS(TAPS), .QW(QUANTIZE_WIDTH), .KW(KW)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .shift (in_rd_en),
      .clr   (group_done),
      .mac   (state == S_MAC),
      .load  (mac_last),
      .din   (din[g]),
      .h     (coef[k]),
      .k     (k),
      .y     (y[g])
    );
  end
endmodule

// File: tb/tb_fir_cmplx_decim.sv
// Directed bench for fir_cmplx_decim: reset, impulse, latency/backpressure, coefficient gating,
// floor-shift behaviour, saturation/wrap and reset during MAC.
module tb_fir_cmplx_decim;
  localparam int TAPS = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_avail = 1'b0;
  logic        in_rd_en;
  logic [31:0] in_i = '0, in_q = '0;
  logic        coef_wr_en = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [31:0] coef_data = '0;
  logic        out_avail;
  logic        out_rd_en = 1'b0;
  logic [31:0] out_i, out_q;

  int total = 0;
  int bad   = 0;

  fir_cmplx_decim dut (
    .clock(clock), .reset(reset), .in_avail(in_avail), .in_rd_en(in_rd_en),
    .in_i(in_i), .in_q(in_q), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_avail(out_avail), .out_rd_en(out_rd_en),
    .out_i(out_i), .out_q(out_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_coef(input int a, input logic [31:0] d);
    coef_wr_en = 1'b1;
    coef_addr  = 5'(a);
    coef_data  = d;
    @(negedge clock);
    coef_wr_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] q);
    int n = 0;
    in_i = i; in_q = q; in_avail = 1'b1;
    #1;
    while (!in_rd_en && n < 100) begin
      @(negedge clock); #1; n++;
    end
    chk("push_rd_en", 32'(in_rd_en), 32'd1);
    @(negedge clock);
    in_avail = 1'b0;
  endtask

  task automatic get_out(input string tag, input bit check, input logic [31:0] ei, input logic [31:0] eq);
    int n = 0;
    while (!out_avail && n < 100) begin
      @(negedge clock); n++;
    end
    chk({tag, "_avail"}, 32'(out_avail), 32'd1);
    if (check) begin
      chk({tag, "_i"}, out_i, ei);
      chk({tag, "_q"}, out_q, eq);
    end
    out_rd_en = 1'b1;
    @(negedge clock);
    out_rd_en = 1'b0;
    chk({tag, "_drop"}, 32'(out_avail), 32'd0);
  endtask

  initial begin
    // reset held with upstream offering data
    in_avail = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_rd_en", 32'(in_rd_en), 32'd0);
    chk("rst_avail", 32'(out_avail), 32'd0);
    chk("rst_i", out_i, 32'd0);
    chk("rst_q", out_q, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("rel_rd_en", 32'(in_rd_en), 32'd1);
    reset = 1'b0; in_avail = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // impulse with h[k] = k in Q10
    for (int t = 0; t < TAPS; t++) wr_coef(t, 32'(t * 1024));
    push(32'd1024, 32'hFFFFFC00);
    for (int t = 0; t < 7; t++) push(32'd0, 32'd0);

    // latency + backpressure, plus a coefficient write that must be dropped in MAC
    in_avail = 1'b1;
    for (int c = 1; c <= TAPS; c++) begin
      if (c == 5) begin coef_wr_en = 1'b1; coef_addr = 5'd7; coef_data = 32'd0; end
      @(negedge clock);
      coef_wr_en = 1'b0;
      if (c < TAPS) chk("lat_wait", 32'({out_avail, in_rd_en}), 32'd0);
      else          chk("lat_hit", 32'(out_avail), 32'd1);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      chk("hold_ctl", 32'({out_avail, in_rd_en}), 32'd2);
      chk("hold_i", out_i, 32'd7168);
    end
    in_avail = 1'b0;
    get_out("out1", 1'b1, 32'd7168, 32'hFFFFE400);

    // IDLE write takes effect: h[15] = 2 in Q10
    wr_coef(15, 32'd2048);
    for (int t = 0; t < 8; t++) push(32'd0, 32'd0);
    get_out("out2", 1'b1, 32'd2048, 32'hFFFFF800);
    for (int t = 0; t < 8; t++) push(32'd0, 32'd0);
    get_out("out3", 1'b1, 32'd0, 32'd0);

    // arithmetic shift floors: h[0]=1 on x=-1 contributes -1, on x=+1 contributes 0
    wr_coef(0, 32'd1);
    for (int t = 0; t < 8; t++) push(32'hFFFFFFFF, 32'd1);
    get_out("floor", 1'b1, 32'hFFFFFFE3, 32'd28);

    // 20 * 2^50 overflows the output width
    for (int t = 0; t < TAPS; t++) wr_coef(t, 32'h40000000);
    for (int g = 0; g < 3; g++) begin
      for (int t = 0; t < 8; t++) push(32'h40000000, 32'h40000000);
      if (g < 2) get_out("sat_fill", 1'b0, 32'd0, 32'd0);
    end
`ifdef FIR_CMPLX_SAT_EN
    get_out("sat", 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF);
`else
    get_out("wrap", 1'b1, 32'h00000000, 32'h00000000);
`endif

    // reset during MAC abandons the computation and clears coefficients
    for (int t = 0; t < 8; t++) push(32'h1000, 32'h1000);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_avail", 32'(out_avail), 32'd0);
    chk("mid_rst_i", out_i, 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      chk("post_rst_idle", 32'(out_avail), 32'd0);
    end
    for (int t = 0; t < 7; t++) push(32'h12345, 32'h777);
    repeat (25) @(negedge clock);
    chk("seven_pairs", 32'(out_avail), 32'd0);
    push(32'h12345, 32'h777);
    get_out("post_rst", 1'b1, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
